// File: rtl/bf_insn_fetch.sv
// Brainfuck program loader: filters ASCII command bytes into 3-bit opcodes, buffers them
// in a FIFO and tracks bracket nesting. Define BF_FETCH_STATS_EN to enable the op_count counter.
module bf_insn_fetch #(
    parameter int unsigned DEPTH_W = 2,
    parameter int unsigned NEST_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2:0]        op_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [NEST_W-1:0] nest_depth,
    output logic              done,
    output logic              err_unbalanced,
    output logic [7:0]        op_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_W;
    localparam int unsigned PTR_W = DEPTH_W + 1;
    localparam logic [NEST_W-1:0] NEST_MAX = '1;

    typedef enum logic {
        S_LOAD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [NEST_W-1:0] r_nest_depth;
    logic              r_err;

    logic       w_full;
    logic       w_empty;
    logic       w_is_cmd;
    logic [2:0] w_op;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_nul;

    // Extra pointer bit separates full from empty
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_W] != r_rd_ptr[DEPTH_W]) &&
                     (r_wr_ptr[DEPTH_W-1:0] == r_rd_ptr[DEPTH_W-1:0]);

    always_comb begin
        w_is_cmd = 1'b1;
        w_op     = 3'd0;
        case (in_data)
            8'h3E:   w_op = 3'd0;
            8'h3C:   w_op = 3'd1;
            8'h2B:   w_op = 3'd2;
            8'h2D:   w_op = 3'd3;
            8'h2E:   w_op = 3'd4;
            8'h2C:   w_op = 3'd5;
            8'h5B:   w_op = 3'd6;
            8'h5D:   w_op = 3'd7;
            default: w_is_cmd = 1'b0;
        endcase
    end

    assign in_ready = (r_state == S_LOAD) && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_is_cmd;
    assign w_nul    = w_accept && (in_data == 8'h00);
    assign w_pop    = op_valid && op_ready;

    assign op_valid       = !w_empty;
    assign op_data        = r_mem[r_rd_ptr[DEPTH_W-1:0]];
    assign done           = (r_state == S_DONE);
    assign nest_depth     = r_nest_depth;
    assign err_unbalanced = r_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_state_next;
    end

    // DONE is terminal until reset
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_LOAD && w_nul) w_state_next = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[DEPTH_W-1:0]] <= w_op;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Bracket depth saturates at both ends; overflow/underflow still enqueue the opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nest_depth <= '0;
            r_err        <= 1'b0;
        end else if (w_push && w_op == 3'd6) begin
            if (r_nest_depth == NEST_MAX) r_err <= 1'b1;
            else                          r_nest_depth <= r_nest_depth + NEST_W'(1);
        end else if (w_push && w_op == 3'd7) begin
            if (r_nest_depth == '0) r_err <= 1'b1;
            else                    r_nest_depth <= r_nest_depth - NEST_W'(1);
        end else if (w_nul && r_nest_depth != '0) begin
            r_err <= 1'b1;
        end
    end

`ifdef BF_FETCH_STATS_EN
    logic [7:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst)                              r_op_count <= 8'd0;
        else if (w_push && r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
    end

    assign op_count = r_op_count;
`else
    assign op_count = 8'd0;
`endif

endmodule

// File: doc/bf_insn_fetch.md
# bf_insn_fetch

Front-end program loader for the Brainfuck core in `tt_um_brainfck_asic`. It sits between the `ui_in` byte pins and the execution core. It takes ASCII program bytes over a valid/ready handshake, filters out non-command characters, and encodes the eight Brainfuck commands into 3-bit opcodes. It buffers the opcodes in a small FIFO for the core and tracks bracket nesting so an unbalanced program is flagged before execution.

## Interface
Parameters:
- `DEPTH_W`, default 2: log2 of FIFO depth (DEPTH = 2^DEPTH_W entries).
- `NEST_W`, default 4: width of the bracket-depth counter (maximum depth 2^NEST_W-1).

Ports:
- `clk`, input, 1: the single clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_data`, input, 8: ASCII program byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block accepts a byte this cycle.
- `op_data`, output, 3: opcode at the FIFO head.
- `op_valid`, output, 1: FIFO not empty.
- `op_ready`, input, 1: core consumes the head opcode.
- `nest_depth`, output, NEST_W: current count of open `[`.
- `done`, output, 1: end-of-program byte seen. Sticky.
- `err_unbalanced`, output, 1: nesting error. Sticky.
- `op_count`, output, 8: number of opcodes enqueued, saturating. See Configuration.

## Operation
- Opcode encoding:
  - `>`=0, `<`=1, `+`=2, `-`=3
  - `.`=4, `,`=5, `[`=6, `]`=7
- Accept condition: `in_valid && in_ready`.
- Accepted command byte: written to the FIFO tail.
- Accepted byte 0x00 (NUL): sets `done`; nothing is enqueued.
- Any other accepted byte: consumed and discarded. No FIFO write, no state change.
- `in_ready` = `!done && !full`, derived from registered state only.
  - When the FIFO is full, a same-cycle pop does not open a push slot.
- Pop condition: `op_valid && op_ready`. `op_data` always reflects the head entry; it is undefined when `op_valid`=0.
- Simultaneous push and pop (FIFO neither empty nor full): occupancy is unchanged and entry order is preserved.
- Nesting tracking, applied at acceptance time:
  - `[` increments `nest_depth`. At maximum depth, `nest_depth` saturates and `err_unbalanced` is set; the opcode is still enqueued.
  - `]` decrements `nest_depth`. At 0, `nest_depth` stays 0 and `err_unbalanced` is set; the opcode is still enqueued.
  - NUL accepted with `nest_depth`≠0 sets `err_unbalanced`.
- State machine:
  - LOAD: accepting bytes. Transitions to DONE on NUL.
  - DONE: `in_ready`=0 and the FIFO only drains. Stays in DONE until `rst`.

## Timing
- Reset values:
  - `in_ready`=1, `op_valid`=0, `op_data`=0
  - `nest_depth`=0, `done`=0, `err_unbalanced`=0, `op_count`=0
  - FIFO empty, state LOAD.
- Reset mid-operation: all of the above in the cycle after `rst` is sampled high. FIFO contents are discarded.
- Latency: a byte accepted in cycle N into an empty FIFO gives `op_valid`=1 and the matching `op_data` in cycle N+1. There is no combinational bypass.
- `done`, `err_unbalanced` and `nest_depth` update in the cycle after the accepting edge.
- No combinational path from `op_ready` to `in_ready`, or from `in_valid` to `op_valid`.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.

## Configuration
- `BF_FETCH_STATS_EN` defined:
  - `op_count` increments on every FIFO push and saturates at 255.
  - It is not incremented for discarded bytes or NUL.
- `BF_FETCH_STATS_EN` not defined:
  - The `op_count` port is still present, driven constant 0.
  - No counter register is synthesised.

## Test plan
- Reset, then stream "+>." with `op_ready`=1: `op_data` sequence 2, 0, 4. First `op_valid` is one cycle after the first accept.
- Stream "a+ b\n-" with `op_ready`=1: only opcodes 2, 3 are emitted. `in_ready` stays 1 throughout.
- Hold `op_ready`=0 and offer 5 command bytes (DEPTH=4): exactly 4 accepted, then `in_ready`=0. Raise `op_ready`: the 5th byte is accepted no earlier than one cycle after the first pop, and order is preserved.
- Stream "[[]" then NUL: `nest_depth` goes 1, 2, 1; `done`=1 and `err_unbalanced`=1 after NUL. `in_ready`=0 afterwards.
- Stream "]": opcode 7 is enqueued, `nest_depth`=0, `err_unbalanced`=1. Assert `rst` for one cycle: all outputs return to reset values.
- With `BF_FETCH_STATS_EN`: 300 `+` bytes drained continuously give `op_count`=255. Without the macro, `op_count`=0 throughout.
